// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared FFT stage-control constants, phase codes and state encoding
package fft_ctrl_pkg;

    localparam int TW_AW_DEFAULT = 9;
    localparam int FFT_N         = 512;

    localparam logic [1:0] PH_FILL = 2'd0;
    localparam logic [1:0] PH_BF   = 2'd1;
    localparam logic [1:0] PH_TW   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/sdf_stage_ctrl_if.sv
// rtl/sdf_stage_ctrl_if.sv - sample handshake and stage-control bus for one SDF stage
interface sdf_stage_ctrl_if #(parameter int TW_AW = fft_ctrl_pkg::TW_AW_DEFAULT);

    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             dl_en;
    logic [1:0]       phase;
    logic [TW_AW-1:0] tw_addr;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic             frame_err;

    modport master (
        output in_valid, in_last,
        input  in_ready, dl_en, phase, tw_addr, out_valid, out_last, busy, frame_err
    );

    modport slave (
        input  in_valid, in_last,
        output in_ready, dl_en, phase, tw_addr, out_valid, out_last, busy, frame_err
    );

endinterface

// File: rtl/sdf_win_counter.sv
// rtl/sdf_win_counter.sv - mod-2D window counter with clear, wrap/half/D-1 flags
module sdf_win_counter #(
    parameter int LOG_D = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           clr,
    output logic [LOG_D:0] cnt,
    output logic           wrap,
    output logic           half,
    output logic           at_dm1
);

    localparam logic [LOG_D:0] D_M1 = (LOG_D+1)'((1 << LOG_D) - 1);

    // Clear wins over increment so a frame abort or flush end lands on 0, not 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign wrap   = &cnt;
    assign half   = cnt[LOG_D];
    assign at_dm1 = (cnt == D_M1);

endmodule

// File: rtl/sdf_stage_ctrl.sv
// rtl/sdf_stage_ctrl.sv - radix-2 SDF stage controller: fill/butterfly/twiddle sequencing and drain
module sdf_stage_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int LOG_D = 2,
    parameter int TW_AW = TW_AW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    sdf_stage_ctrl_if.slave  s
);

    state_t           state, state_nxt;
    logic             adv;
    logic             clr;
    logic             in_ready;
    logic [1:0]       phase;
    logic             out_valid;
    logic             out_last;
    logic             frame_err;
    logic [LOG_D:0]   cnt;
    logic             wrap, half, at_dm1;
    logic [TW_AW-1:0] tw_raw;

    assign in_ready = (state != ST_FLUSH);
    // rst_n gates adv so every output except in_ready reads 0 while reset is held.
    assign adv      = rst_n & ((s.in_valid & in_ready) | (state == ST_FLUSH));

    sdf_win_counter #(.LOG_D(LOG_D)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (adv),
        .clr    (clr),
        .cnt    (cnt),
        .wrap   (wrap),
        .half   (half),
        .at_dm1 (at_dm1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        frame_err = 1'b0;
        out_last  = 1'b0;
        phase     = PH_FILL;
        out_valid = 1'b0;
        case (state)
            ST_IDLE, ST_PRIME: begin
                if (adv) begin
                    if (s.in_last) begin
                        frame_err = 1'b1;
                        clr       = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (at_dm1) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_PRIME;
                    end
                end
            end
            ST_RUN: begin
                phase     = half ? PH_BF : PH_TW;
                out_valid = adv;
                if (adv && s.in_last) begin
                    if (wrap) begin
                        state_nxt = ST_FLUSH;
                    end else begin
                        frame_err = 1'b1;
                        clr       = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                phase     = PH_TW;
                out_valid = 1'b1;
                if (at_dm1) begin
                    out_last  = 1'b1;
                    clr       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Twiddle index walks the low half of the window, scaled into the 512-entry ROM.
    generate
        if (LOG_D == 0) begin : g_tw_zero
            assign tw_raw = '0;
        end else begin : g_tw_shift
            assign tw_raw = {{(TW_AW-LOG_D){1'b0}}, cnt[LOG_D-1:0]} << (TW_AW-1-LOG_D);
        end
    endgenerate

    assign s.in_ready  = in_ready;
    assign s.dl_en     = adv;
    assign s.phase     = phase;
    assign s.tw_addr   = (phase == PH_TW) ? tw_raw : '0;
    assign s.out_valid = out_valid;
    assign s.out_last  = out_last;
    assign s.busy      = (state != ST_IDLE);
    assign s.frame_err = frame_err;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb/tb_sdf_stage_ctrl.sv - self-checking bench for sdf_stage_ctrl against a sample-count reference model
module tb_sdf_stage_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdf_stage_ctrl_if #(.TW_AW(9)) b2 ();
    sdf_stage_ctrl_if #(.TW_AW(9)) b8 ();

    sdf_stage_ctrl #(.LOG_D(2), .TW_AW(9)) dut2 (.clk(clk), .rst_n(rst_n), .s(b2.slave));
    sdf_stage_ctrl #(.LOG_D(8), .TW_AW(9)) dut8 (.clk(clk), .rst_n(rst_n), .s(b8.slave));

    // {in_ready, dl_en, phase[1:0], tw_addr[8:0], out_valid, out_last, busy, frame_err}
    logic [16:0] obs2, obs8;
    assign obs2 = {b2.in_ready, b2.dl_en, b2.phase, b2.tw_addr, b2.out_valid, b2.out_last, b2.busy, b2.frame_err};
    assign obs8 = {b8.in_ready, b8.dl_en, b8.phase, b8.tw_addr, b8.out_valid, b8.out_last, b8.busy, b8.frame_err};

    localparam logic [16:0] RST_EXP = 17'h10000;

    int n_cmp  = 0;
    int n_fail = 0;
    int k2 = 0, fl2 = -1;
    int k8 = 0, fl8 = -1;

    // k = samples accepted in the current frame, fl = flush index (-1 when not draining)
    function automatic logic [16:0] ref_out(input int d, input int sh, input int k, input int fl,
                                            input bit v, input bit l);
        logic       rdy, dl, ov, ol, bz, fe;
        logic [1:0] ph;
        int         tw;
        if (fl >= 0) begin
            rdy = 1'b0; dl = 1'b1; ph = 2'd2; tw = fl << sh;
            ov = 1'b1; ol = (fl == d - 1); bz = 1'b1; fe = 1'b0;
        end else begin
            rdy = 1'b1; dl = v;
            if (k < d)                ph = 2'd0;
            else if ((k / d) % 2 == 1) ph = 2'd1;
            else                      ph = 2'd2;
            tw = (ph == 2'd2) ? ((k % d) << sh) : 0;
            ov = v && (k >= d); ol = 1'b0; bz = (k > 0);
            fe = v && l && ((k < d) || (((k + 1) % (2 * d)) != 0));
        end
        return {rdy, dl, ph, 9'(tw), ov, ol, bz, fe};
    endfunction

    task automatic model_step(input int d, input bit v, input bit l, inout int k, inout int fl);
        if (fl >= 0) begin
            fl++;
            if (fl == d) begin fl = -1; k = 0; end
        end else if (v) begin
            if (l) begin
                if ((k < d) || (((k + 1) % (2 * d)) != 0)) k = 0;
                else begin k = 0; fl = 0; end
            end else begin
                k++;
            end
        end
    endtask

    task automatic test_reset();
        b2.in_valid = 1'b1; b2.in_last = 1'b0;
        b8.in_valid = 1'b1; b8.in_last = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs2 !== RST_EXP) begin n_fail++; $display("FAIL reset_d2: got %h want %h", obs2, RST_EXP); end
        n_cmp++;
        if (obs8 !== RST_EXP) begin n_fail++; $display("FAIL reset_d8: got %h want %h", obs8, RST_EXP); end
        b2.in_valid = 1'b0; b8.in_valid = 1'b0; b8.in_last = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        k2 = 0; fl2 = -1; k8 = 0; fl8 = -1;
    endtask

    task automatic test_basic_frame();
        bit v, l;
        int nout = 0, nlast = 0;
        for (int c = 0; c < 14; c++) begin
            v = (c < 8); l = (c == 7);
            b2.in_valid = v; b2.in_last = l;
            @(negedge clk);
            n_cmp++;
            if (obs2 !== ref_out(4, 6, k2, fl2, v, l)) begin
                n_fail++; $display("FAIL basic cyc%0d: got %h want %h", c, obs2, ref_out(4, 6, k2, fl2, v, l));
            end
            nout += int'(b2.out_valid); nlast += int'(b2.out_last);
            model_step(4, v, l, k2, fl2);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (nout != 8 || nlast != 1) begin n_fail++; $display("FAIL basic_counts: got %0d/%0d want 8/1", nout, nlast); end
    endtask

    task automatic test_gaps();
        bit v, l;
        int na = 0, nout = 0, ndl = 0;
        for (int c = 0; c < 40; c++) begin
            v = (c % 3 != 2) && (na < 16); l = v && (na == 15);
            b2.in_valid = v; b2.in_last = l;
            @(negedge clk);
            n_cmp++;
            if (obs2 !== ref_out(4, 6, k2, fl2, v, l)) begin
                n_fail++; $display("FAIL gaps cyc%0d: got %h want %h", c, obs2, ref_out(4, 6, k2, fl2, v, l));
            end
            nout += int'(b2.out_valid); ndl += int'(b2.dl_en);
            if (v && b2.in_ready) na++;
            model_step(4, v, l, k2, fl2);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (nout != 16 || ndl != 20) begin n_fail++; $display("FAIL gaps_counts: got %0d/%0d want 16/20", nout, ndl); end
    endtask

    task automatic test_misaligned();
        bit v, l;
        bit lq[$];
        int nerr = 0, nlast = 0, nout = 0;
        for (int i = 0; i < 6; i++) lq.push_back(i == 5);
        for (int i = 0; i < 8; i++) lq.push_back(i == 7);
        for (int c = 0; c < 24; c++) begin
            v = (lq.size() > 0); l = v ? lq[0] : 1'b0;
            b2.in_valid = v; b2.in_last = l;
            @(negedge clk);
            n_cmp++;
            if (obs2 !== ref_out(4, 6, k2, fl2, v, l)) begin
                n_fail++; $display("FAIL misalign cyc%0d: got %h want %h", c, obs2, ref_out(4, 6, k2, fl2, v, l));
            end
            nerr += int'(b2.frame_err); nlast += int'(b2.out_last); nout += int'(b2.out_valid);
            if (v && b2.in_ready) void'(lq.pop_front());
            model_step(4, v, l, k2, fl2);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (nerr != 1 || nlast != 1 || nout != 10 || lq.size() != 0) begin
            n_fail++; $display("FAIL misalign_counts: got err%0d last%0d out%0d left%0d want 1/1/10/0", nerr, nlast, nout, lq.size());
        end
    endtask

    task automatic test_async_reset();
        bit v, l;
        int nlast = 0, nout = 0;
        for (int c = 0; c < 5; c++) begin
            b2.in_valid = 1'b1; b2.in_last = 1'b0;
            @(posedge clk); #1;
        end
        b2.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs2 !== RST_EXP) begin n_fail++; $display("FAIL async_rst_now: got %h want %h", obs2, RST_EXP); end
        @(posedge clk); #1;
        n_cmp++;
        if (obs2 !== RST_EXP) begin n_fail++; $display("FAIL async_rst_hold: got %h want %h", obs2, RST_EXP); end
        rst_n = 1'b1;
        k2 = 0; fl2 = -1;
        for (int c = 0; c < 14; c++) begin
            v = (c < 8); l = (c == 7);
            b2.in_valid = v; b2.in_last = l;
            @(negedge clk);
            n_cmp++;
            if (obs2 !== ref_out(4, 6, k2, fl2, v, l)) begin
                n_fail++; $display("FAIL post_rst cyc%0d: got %h want %h", c, obs2, ref_out(4, 6, k2, fl2, v, l));
            end
            nout += int'(b2.out_valid); nlast += int'(b2.out_last);
            model_step(4, v, l, k2, fl2);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (nout != 8 || nlast != 1) begin n_fail++; $display("FAIL post_rst_counts: got %0d/%0d want 8/1", nout, nlast); end
    endtask

    task automatic test_long_frame();
        bit v, l;
        int na = 0, nout = 0, nlast = 0, nbad = 0;
        for (int c = 0; c < 1200; c++) begin
            v = (na < 512) && ($urandom_range(0, 3) != 0); l = v && (na == 511);
            b8.in_valid = v; b8.in_last = l;
            @(negedge clk);
            if (obs8 !== ref_out(256, 0, k8, fl8, v, l)) begin
                nbad++;
                if (nbad <= 4) $display("FAIL long cyc%0d: got %h want %h", c, obs8, ref_out(256, 0, k8, fl8, v, l));
            end
            nout += int'(b8.out_valid); nlast += int'(b8.out_last);
            if (v && b8.in_ready) na++;
            model_step(256, v, l, k8, fl8);
            @(posedge clk); #1;
        end
        b8.in_valid = 1'b0; b8.in_last = 1'b0;
        n_cmp++;
        if (nbad != 0) begin n_fail++; $display("FAIL long_cycles: got %0d bad cycles want 0", nbad); end
        n_cmp++;
        if (nout != 512 || nlast != 1 || na != 512) begin
            n_fail++; $display("FAIL long_counts: got out%0d last%0d in%0d want 512/1/512", nout, nlast, na);
        end
    endtask

    task automatic test_back_to_back();
        bit v, l;
        bit lq[$];
        int total = 0, nfr = 0, nout = 0, nlast = 0, nstall = 0, nbad = 0, len;
        for (int f = 0; f < 4; f++) begin
            len = 8 * $urandom_range(1, 3);
            for (int i = 0; i < len; i++) lq.push_back(i == len - 1);
            total += len; nfr++;
        end
        for (int c = 0; c < 140; c++) begin
            v = (lq.size() > 0); l = v ? lq[0] : 1'b0;
            b2.in_valid = v; b2.in_last = l;
            @(negedge clk);
            if (obs2 !== ref_out(4, 6, k2, fl2, v, l)) begin
                nbad++;
                if (nbad <= 4) $display("FAIL b2b cyc%0d: got %h want %h", c, obs2, ref_out(4, 6, k2, fl2, v, l));
            end
            nout += int'(b2.out_valid); nlast += int'(b2.out_last);
            if (v && !b2.in_ready) nstall++;
            if (v && b2.in_ready) void'(lq.pop_front());
            model_step(4, v, l, k2, fl2);
            @(posedge clk); #1;
        end
        b2.in_valid = 1'b0; b2.in_last = 1'b0;
        n_cmp++;
        if (nbad != 0) begin n_fail++; $display("FAIL b2b_cycles: got %0d bad cycles want 0", nbad); end
        n_cmp++;
        if (nout != total || nlast != nfr || lq.size() != 0) begin
            n_fail++; $display("FAIL b2b_counts: got out%0d last%0d left%0d want %0d/%0d/0", nout, nlast, lq.size(), total, nfr);
        end
        n_cmp++;
        if (nstall != 4 * (nfr - 1)) begin n_fail++; $display("FAIL b2b_stalls: got %0d want %0d", nstall, 4 * (nfr - 1)); end
    endtask

    initial begin
        b2.in_valid = 1'b0; b2.in_last = 1'b0;
        b8.in_valid = 1'b0; b8.in_last = 1'b0;
        test_reset();
        test_basic_frame();
        test_gaps();
        test_misaligned();
        test_async_reset();
        test_long_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
